// File: rtl/ps2_line_buffer.sv
// PS/2 set-2 scan-code to ASCII line editor: filters break/extended codes,
// collects printable keys into a line and presents it on enter via valid/ready.
module ps2_line_buffer #(
    parameter int DEPTH = 4,
    localparam int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 key_pressed,
    input  logic [7:0]           key_data,
    input  logic                 line_ready,
    output logic                 line_valid,
    output logic [8*DEPTH-1:0]   line_data,
    output logic [LEN_W-1:0]     line_len,
    output logic                 echo_valid,
    output logic [7:0]           echo_char,
    output logic                 overflow
);

    typedef enum logic [1:0] {D_IDLE, D_BRK, D_EXT, D_EXT_BRK} decState_t;
    typedef enum logic {L_EDIT, L_HOLD} lineState_t;

    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    decState_t          decState_q, decState_d;
    lineState_t         lineState_q, lineState_d;
    logic [8*DEPTH-1:0] data_q, data_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               echoValid_q, echoValid_d;
    logic [7:0]         echoChar_q, echoChar_d;
    logic               overflow_q, overflow_d;
    logic               isMake;
    logic [7:0]         makeChar;

    // Returns the ASCII for a printable make code, 0x00 for anything else.
    function automatic logic [7:0] mapChar(input logic [7:0] code);
        case (code)
            8'h1C: mapChar = 8'h41;  8'h32: mapChar = 8'h42;  8'h21: mapChar = 8'h43;
            8'h23: mapChar = 8'h44;  8'h24: mapChar = 8'h45;  8'h2B: mapChar = 8'h46;
            8'h34: mapChar = 8'h47;  8'h33: mapChar = 8'h48;  8'h43: mapChar = 8'h49;
            8'h3B: mapChar = 8'h4A;  8'h42: mapChar = 8'h4B;  8'h4B: mapChar = 8'h4C;
            8'h3A: mapChar = 8'h4D;  8'h31: mapChar = 8'h4E;  8'h44: mapChar = 8'h4F;
            8'h4D: mapChar = 8'h50;  8'h15: mapChar = 8'h51;  8'h2D: mapChar = 8'h52;
            8'h1B: mapChar = 8'h53;  8'h2C: mapChar = 8'h54;  8'h3C: mapChar = 8'h55;
            8'h2A: mapChar = 8'h56;  8'h1D: mapChar = 8'h57;  8'h22: mapChar = 8'h58;
            8'h35: mapChar = 8'h59;  8'h1A: mapChar = 8'h5A;
            8'h45: mapChar = 8'h30;  8'h16: mapChar = 8'h31;  8'h1E: mapChar = 8'h32;
            8'h26: mapChar = 8'h33;  8'h25: mapChar = 8'h34;  8'h2E: mapChar = 8'h35;
            8'h36: mapChar = 8'h36;  8'h3D: mapChar = 8'h37;  8'h3E: mapChar = 8'h38;
            8'h46: mapChar = 8'h39;  8'h29: mapChar = 8'h20;
            default: mapChar = 8'h00;
        endcase
    endfunction

    always_comb begin
        decState_d = decState_q;
        isMake     = 1'b0;
        if (key_pressed) begin
            case (decState_q)
                D_IDLE: begin
                    if (key_data == CODE_BRK)      decState_d = D_BRK;
                    else if (key_data == CODE_EXT) decState_d = D_EXT;
                    else                           isMake     = 1'b1;
                end
                D_EXT:   decState_d = (key_data == CODE_BRK) ? D_EXT_BRK : D_IDLE;
                default: decState_d = D_IDLE;
            endcase
        end
    end

    assign makeChar = mapChar(key_data);

    // A line in L_HOLD is frozen; make codes arriving then are simply dropped.
    always_comb begin
        lineState_d = lineState_q;
        data_d      = data_q;
        len_d       = len_q;
        echoValid_d = 1'b0;
        echoChar_d  = echoChar_q;
        overflow_d  = overflow_q;
        case (lineState_q)
            L_EDIT: begin
                if (isMake) begin
                    if (makeChar != 8'h00) begin
                        if (len_q < LEN_W'(DEPTH)) begin
                            data_d      = data_q << 8;
                            data_d[7:0] = makeChar;
                            len_d       = len_q + LEN_W'(1);
                            echoValid_d = 1'b1;
                            echoChar_d  = makeChar;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (key_data == CODE_BKSP && len_q != '0) begin
                        data_d = data_q >> 8;
                        len_d  = len_q - LEN_W'(1);
                    end else if (key_data == CODE_ENTER && len_q != '0) begin
                        lineState_d = L_HOLD;
                    end
                end
            end
            default: begin
                if (line_ready) begin
                    lineState_d = L_EDIT;
                    data_d      = '0;
                    len_d       = '0;
                    overflow_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            decState_q  <= D_IDLE;
            lineState_q <= L_EDIT;
            data_q      <= '0;
            len_q       <= '0;
            echoValid_q <= 1'b0;
            echoChar_q  <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            decState_q  <= decState_d;
            lineState_q <= lineState_d;
            data_q      <= data_d;
            len_q       <= len_d;
            echoValid_q <= echoValid_d;
            echoChar_q  <= echoChar_d;
            overflow_q  <= overflow_d;
        end
    end

    assign line_valid = (lineState_q == L_HOLD);
    assign line_data  = data_q;
    assign line_len   = len_q;
    assign echo_valid = echoValid_q;
    assign echo_char  = echoChar_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Directed bench for ps2_line_buffer: hand-computed expectations checked with
// immediate assertions after each stimulus step.
module tb_ps2_line_buffer;

    logic        clock;
    logic        reset;
    logic        keyPressed;
    logic [7:0]  keyData;
    logic        lineReady;
    logic        lineValid;
    logic [31:0] lineData;
    logic [2:0]  lineLen;
    logic        echoValid;
    logic [7:0]  echoChar;
    logic        overflowFlag;

    int checks   = 0;
    int failures = 0;

    ps2_line_buffer #(.DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_pressed (keyPressed),
        .key_data    (keyData),
        .line_ready  (lineReady),
        .line_valid  (lineValid),
        .line_data   (lineData),
        .line_len    (lineLen),
        .echo_valid  (echoValid),
        .echo_char   (echoChar),
        .overflow    (overflowFlag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One clock cycle: optional key strobe and line_ready level, sampled 1ns after the edge.
    task automatic applyStimulus(input logic press, input logic [7:0] code, input logic ready);
        @(negedge clock);
        keyPressed = press;
        keyData    = code;
        lineReady  = ready;
        @(posedge clock);
        #1;
        keyPressed = 1'b0;
        lineReady  = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".valid"}, {31'd0, lineValid}, 32'd0);
        checkOutput({tag, ".data"}, lineData, 32'd0);
        checkOutput({tag, ".len"}, {29'd0, lineLen}, 32'd0);
        checkOutput({tag, ".echoV"}, {31'd0, echoValid}, 32'd0);
        checkOutput({tag, ".echoC"}, {24'd0, echoChar}, 32'd0);
        checkOutput({tag, ".ovf"}, {31'd0, overflowFlag}, 32'd0);
    endtask

    initial begin
        logic [7:0] filterSeq [8];
        filterSeq = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};

        reset      = 1'b1;
        keyPressed = 1'b0;
        keyData    = 8'h00;
        lineReady  = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        checkAllZero("reset");

        // "HI" then enter
        applyStimulus(1'b1, 8'h33, 1'b0);
        checkOutput("hi.echoV1", {31'd0, echoValid}, 32'd1);
        checkOutput("hi.echoC1", {24'd0, echoChar}, 32'h48);
        applyStimulus(1'b1, 8'h43, 1'b0);
        checkOutput("hi.echoV2", {31'd0, echoValid}, 32'd1);
        checkOutput("hi.echoC2", {24'd0, echoChar}, 32'h49);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("hi.valid", {31'd0, lineValid}, 32'd1);
        checkOutput("hi.len", {29'd0, lineLen}, 32'd2);
        checkOutput("hi.data", lineData, 32'h0000_4849);
        checkOutput("hi.echoV3", {31'd0, echoValid}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("hi.xferValid", {31'd0, lineValid}, 32'd0);
        checkOutput("hi.xferLen", {29'd0, lineLen}, 32'd0);
        checkOutput("hi.xferData", lineData, 32'd0);

        // Break and extended filtering
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, filterSeq[i], 1'b0);
            checkOutput($sformatf("filt.echoV%0d", i), {31'd0, echoValid},
                        (i == 0) ? 32'd1 : 32'd0);
        end
        checkOutput("filt.len", {29'd0, lineLen}, 32'd1);
        checkOutput("filt.data", lineData, 32'h41);
        checkOutput("filt.echoC", {24'd0, echoChar}, 32'h41);

        // Backspace down to empty, then empty enter/backspace are no-ops
        applyStimulus(1'b1, 8'h66, 1'b0);
        checkOutput("bs.len", {29'd0, lineLen}, 32'd0);
        checkOutput("bs.data", lineData, 32'd0);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("emptyEnter.valid", {31'd0, lineValid}, 32'd0);
        checkOutput("emptyEnter.len", {29'd0, lineLen}, 32'd0);
        applyStimulus(1'b1, 8'h66, 1'b0);
        checkOutput("emptyBs.len", {29'd0, lineLen}, 32'd0);
        checkOutput("emptyBs.valid", {31'd0, lineValid}, 32'd0);

        // Fill to DEPTH, overflow on the fifth key
        applyStimulus(1'b1, 8'h1C, 1'b0);
        applyStimulus(1'b1, 8'h32, 1'b0);
        applyStimulus(1'b1, 8'h21, 1'b0);
        applyStimulus(1'b1, 8'h23, 1'b0);
        checkOutput("full.ovfBefore", {31'd0, overflowFlag}, 32'd0);
        applyStimulus(1'b1, 8'h24, 1'b0);
        checkOutput("full.data", lineData, 32'h4142_4344);
        checkOutput("full.len", {29'd0, lineLen}, 32'd4);
        checkOutput("full.ovf", {31'd0, overflowFlag}, 32'd1);
        checkOutput("full.echoV", {31'd0, echoValid}, 32'd0);
        checkOutput("full.echoC", {24'd0, echoChar}, 32'h44);
        applyStimulus(1'b1, 8'h66, 1'b0);
        checkOutput("fullBs.data", lineData, 32'h0041_4243);
        checkOutput("fullBs.len", {29'd0, lineLen}, 32'd3);
        checkOutput("fullBs.ovf", {31'd0, overflowFlag}, 32'd1);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("hold.valid", {31'd0, lineValid}, 32'd1);

        // Held line ignores keys while line_ready stays low
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, (i == 5) ? 8'h66 : 8'h2D, 1'b0);
            checkOutput($sformatf("hold.echoV%0d", i), {31'd0, echoValid}, 32'd0);
        end
        checkOutput("hold.data", lineData, 32'h0041_4243);
        checkOutput("hold.len", {29'd0, lineLen}, 32'd3);
        checkOutput("hold.ovf", {31'd0, overflowFlag}, 32'd1);
        checkOutput("hold.valid2", {31'd0, lineValid}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("xfer.valid", {31'd0, lineValid}, 32'd0);
        checkOutput("xfer.len", {29'd0, lineLen}, 32'd0);
        checkOutput("xfer.ovf", {31'd0, overflowFlag}, 32'd0);
        applyStimulus(1'b1, 8'h16, 1'b0);
        checkOutput("post.echoV", {31'd0, echoValid}, 32'd1);
        checkOutput("post.echoC", {24'd0, echoChar}, 32'h31);
        checkOutput("post.len", {29'd0, lineLen}, 32'd1);

        // line_ready while idle does nothing; space maps to 0x20
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("idleReady.len", {29'd0, lineLen}, 32'd1);
        applyStimulus(1'b1, 8'h29, 1'b0);
        checkOutput("space.echoC", {24'd0, echoChar}, 32'h20);
        checkOutput("space.data", lineData, 32'h0000_3120);

        // Key during the transfer cycle is dropped
        applyStimulus(1'b1, 8'h5A, 1'b0);
        applyStimulus(1'b1, 8'h45, 1'b1);
        checkOutput("xferKey.valid", {31'd0, lineValid}, 32'd0);
        checkOutput("xferKey.echoV", {31'd0, echoValid}, 32'd0);
        checkOutput("xferKey.len", {29'd0, lineLen}, 32'd0);
        applyStimulus(1'b1, 8'h45, 1'b0);
        checkOutput("digit.echoC", {24'd0, echoChar}, 32'h30);
        checkOutput("digit.len", {29'd0, lineLen}, 32'd1);

        // Reset mid-line and mid-prefix
        applyStimulus(1'b1, 8'h1C, 1'b0);
        applyStimulus(1'b1, 8'hF0, 1'b0);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        checkAllZero("midReset");
        applyStimulus(1'b1, 8'h2D, 1'b0);
        checkOutput("afterReset.echoV", {31'd0, echoValid}, 32'd1);
        checkOutput("afterReset.echoC", {24'd0, echoChar}, 32'h52);
        checkOutput("afterReset.len", {29'd0, lineLen}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("echoPulse.width", {31'd0, echoValid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
